vga_scan_ctrl: RTL and testbench



---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_scan_ctrl_if.sv | 25 ++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and colour types for the VGA scan controller.
// Defaults describe 640x480@60. The test-pattern bar table is used only when
// VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [11:0] color_t;

  // Eight vertical colour bars, left to right.
  function automatic color_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Raster and connector signals of the VGA scan controller.
// master: the scan controller. slave: sprite ROM / connector side.
interface vga_scan_ctrl_if;
  import vga_pkg::*;

  color_t     pixel_in;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic       frame_tick;
  logic       hsync;
  logic       vsync;
  color_t     rgb;

  modport master (
    input  pixel_in,
    output h_cnt, v_cnt, valid, frame_tick, hsync, vsync, rgb
  );

  modport slave (
    output pixel_in,
    input  h_cnt, v_cnt, valid, frame_tick, hsync, vsync, rgb
  );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of depth D and width W. D=0 is a plain wire.
// Stages clear asynchronously to RST_VAL.
module vga_delay_line #(
  parameter int           W       = 3,
  parameter int           D       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (D == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stage [D];

      // Shift one stage per enabled tick.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < D; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[D-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: h/v counters, sync decode, ROM-latency
// matching delay line and the registered connector output stage.
// Optional feature macro: VGA_TEST_PATTERN_EN adds test_mode colour bars.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int ROM_LAT  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  vga_scan_ctrl_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_q, v_q;
  logic       tick_q;
  logic       valid_raw, hs_raw, vs_raw;
  color_t     rgb_q;
  logic       hs_q, vs_q;

  // Raster counters; frame_tick is a single-clk pulse after the frame wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (pix_en) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          if (v_q == V_LAST) begin
            v_q    <= '0;
            tick_q <= 1'b1;
          end else begin
            v_q <= v_q + 10'd1;
          end
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  assign valid_raw = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw    = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_raw    = !((v_q >= VS_START) && (v_q < VS_END));

  // Blanking and syncs travel alongside the ROM read so colour and timing
  // reach the connector on the same tick. The test pattern also needs the
  // delayed column to pick a bar.
`ifdef VGA_TEST_PATTERN_EN
  localparam int          DW     = 13;
  localparam logic [DW-1:0] DL_RST = {10'd0, 3'b011};
  logic [DW-1:0] dl_in, dl_out;
  assign dl_in = {h_q, valid_raw, hs_raw, vs_raw};
`else
  localparam int          DW     = 3;
  localparam logic [DW-1:0] DL_RST = 3'b011;
  logic [DW-1:0] dl_in, dl_out;
  assign dl_in = {valid_raw, hs_raw, vs_raw};
`endif

  vga_delay_line #(
    .W       (DW),
    .D       (ROM_LAT),
    .RST_VAL (DL_RST)
  ) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (dl_in),
    .dout (dl_out)
  );

  logic   dly_valid, dly_hs, dly_vs;
  color_t pix_next;

  assign dly_valid = dl_out[2];
  assign dly_hs    = dl_out[1];
  assign dly_vs    = dl_out[0];

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [9:0] bar_full;
  assign bar_full = dl_out[12:3] / BAR_W;
`endif

  // Colour source: ROM data, or the bar generator in test mode.
  always_comb begin
    pix_next = bus.pixel_in;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) pix_next = bar_color(bar_full[2:0]);
`endif
  end

  // Connector output stage; colour forced to black outside the active area.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= dly_valid ? pix_next : 12'h000;
      hs_q  <= dly_hs;
      vs_q  <= dly_vs;
    end
  end

  assign bus.h_cnt      = h_q;
  assign bus.v_cnt      = v_q;
  assign bus.valid      = valid_raw;
  assign bus.frame_tick = tick_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Testbench for vga_scan_ctrl using a shrunk raster (25 x 13) so whole frames
// fit in a short run. Expected connector outputs are queued when a raster
// position is scanned and compared when they emerge from the pipeline.
module tb_vga_scan_ctrl;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef VGA_TEST_PATTERN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int   h;
    int   v;
    logic vld;
    logic hs;
    logic vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  logic tm = 1'b0;

  vga_scan_ctrl_if bus ();

  vga_scan_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .ROM_LAT  (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode (tm),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Sprite ROM model with LAT ticks of read latency.
  logic [11:0] rom_pipe [LAT];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) rom_pipe[i] <= 12'h000;
    end else if (pix_en) begin
      rom_pipe[0] <= {bus.h_cnt[3:0], bus.v_cnt[3:0], 4'h5};
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
  end
  assign bus.pixel_in = rom_pipe[LAT-1];

  int   total = 0;
  int   bad = 0;
  int   mh, mv;
  int   ft_seen, hs_low, vs_low;
  exp_t sb[$];
  exp_t last_out;

  function automatic logic [11:0] bar_ref(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    e.h   = h;
    e.v   = v;
    e.vld = (h < HA) && (v < VA);
    e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    return e;
  endfunction

  function automatic exp_t blank_entry();
    exp_t e;
    e.h = -1; e.v = -1; e.vld = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    return e;
  endfunction

  function automatic logic [11:0] exp_rgb(input exp_t e);
    logic [9:0] hh, vv;
    if (!e.vld) return 12'h000;
    if (tm) return bar_ref(e.h / (HA / 8));
    hh = 10'(e.h);
    vv = 10'(e.v);
    return {hh[3:0], vv[3:0], 4'h5};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic restart_model();
    mh = 0;
    mv = 0;
    sb.delete();
    for (int i = 0; i < LAT; i++) sb.push_back(blank_entry());
    last_out = blank_entry();
  endtask

  // One clk; en selects whether this is a pixel tick.
  task automatic tick(input bit en);
    bit   wrap;
    exp_t cur;
    pix_en = en;
    if (en) sb.push_back(model(mh, mv));
    @(posedge clk);
    #1;
    wrap = 1'b0;
    if (en) begin
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          wrap = 1'b1;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
      last_out = sb.pop_front();
    end
    cur = model(mh, mv);
    chk("h_cnt", 32'(bus.h_cnt), 32'(mh));
    chk("v_cnt", 32'(bus.v_cnt), 32'(mv));
    chk("valid", 32'(bus.valid), 32'(cur.vld));
    chk("frame_tick", 32'(bus.frame_tick), 32'(wrap));
    chk("rgb", 32'(bus.rgb), 32'(exp_rgb(last_out)));
    chk("hsync", 32'(bus.hsync), 32'(last_out.hs));
    chk("vsync", 32'(bus.vsync), 32'(last_out.vs));
    if (!tm && last_out.h == 10 && last_out.v == 3)
      chk("rgb_at_10_3", 32'(bus.rgb), 32'h0A35);
    if (tm && last_out.v == 5 && last_out.h >= 0 && last_out.h < 2)
      chk("bar0_line5", 32'(bus.rgb), 32'h0FFF);
    if (tm && last_out.v == 5 && last_out.h >= 2 && last_out.h < 4)
      chk("bar1_line5", 32'(bus.rgb), 32'h0FF0);
    if (bus.frame_tick) ft_seen++;
    if (en && !bus.hsync) hs_low++;
    if (en && !bus.vsync) vs_low++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state with rst held low.
    #12;
    chk("rst_h_cnt", 32'(bus.h_cnt), 32'd0);
    chk("rst_v_cnt", 32'(bus.v_cnt), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd1);
    chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
    chk("rst_hsync", 32'(bus.hsync), 32'd1);
    chk("rst_vsync", 32'(bus.vsync), 32'd1);
    chk("rst_rgb", 32'(bus.rgb), 32'd0);
    restart_model();
    @(negedge clk);
    rst = 1'b1;

    // Two frames at full pixel rate.
    ft_seen = 0; hs_low = 0; vs_low = 0;
    repeat (2 * HT * VT) tick(1'b1);
    chk("frames_full_rate", 32'(ft_seen), 32'd2);
    chk("hsync_low_ticks", 32'(hs_low), 32'(2 * VT * HS));
    chk("vsync_low_ticks", 32'(vs_low), 32'(2 * HT * VS));

    // One frame with pix_en high on 1 of every 4 clks.
    ft_seen = 0;
    repeat (HT * VT) begin
      tick(1'b1);
      repeat (3) tick(1'b0);
    end
    chk("frames_quarter_rate", 32'(ft_seen), 32'd1);

    // Scan to (20,5), then assert reset between clock edges.
    n = 0;
    while (!(mh == 20 && mv == 5) && n < 2 * HT * VT) begin
      tick(1'b1);
      n++;
    end
    chk("reach_20_5", 32'(n < 2 * HT * VT), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_h_cnt", 32'(bus.h_cnt), 32'd0);
    chk("async_v_cnt", 32'(bus.v_cnt), 32'd0);
    chk("async_rgb", 32'(bus.rgb), 32'd0);
    chk("async_hsync", 32'(bus.hsync), 32'd1);
    chk("async_vsync", 32'(bus.vsync), 32'd1);
    chk("async_frame_tick", 32'(bus.frame_tick), 32'd0);
    restart_model();
    @(negedge clk);
    rst = 1'b1;

    // First frame_tick after release needs a full frame of pixel ticks.
    ft_seen = 0;
    n = 0;
    while (ft_seen == 0 && n < 2 * HT * VT) begin
      tick(1'b1);
      n++;
    end
    chk("ticks_to_first_frame_tick", 32'(n), 32'(HT * VT));

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars for one frame.
    tm = 1'b1;
    repeat (HT * VT) tick(1'b1);
    tm = 1'b0;
    repeat (2 * HT) tick(1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
